// File: rtl/audio_pkg.sv
// Shared audio types and the note divider table used by both tonegen and tone_decoder.
package audio_pkg;

    typedef logic [3:0] note_t;
    typedef logic [2:0] octave_t;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        SEARCH,
        DECIDE
    } tone_dec_state_t;

    localparam int NUM_NOTES   = 12;
    localparam int NUM_OCTAVES = 8;

    // Octave-0 clock divider per note, C first; higher octaves are right shifts of these.
    function automatic logic [11:0] note_div(input note_t n);
        logic [11:0] d;
        case (n)
            4'd0:    d = 12'd1468;
            4'd1:    d = 12'd1386;
            4'd2:    d = 12'd1308;
            4'd3:    d = 12'd1234;
            4'd4:    d = 12'd1165;
            4'd5:    d = 12'd1099;
            4'd6:    d = 12'd1038;
            4'd7:    d = 12'd980;
            4'd8:    d = 12'd924;
            4'd9:    d = 12'd873;
            4'd10:   d = 12'd824;
            4'd11:   d = 12'd777;
            default: d = 12'd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tone_div_rom.sv
// Expected half-period in samples for a (note, octave) pair: tonegen holds each level div+1 samples.
module tone_div_rom
    import audio_pkg::*;
(
    input  note_t       note,
    input  octave_t     octave,
    output logic [11:0] half_period
);

    always_comb begin
        half_period = (note_div(note) >> octave) + 12'd1;
    end

endmodule

// File: rtl/tone_decoder.sv
// Measures the half-period and peak of an incoming square wave and decodes note/octave/volume.
module tone_decoder
    import audio_pkg::*;
#(
    parameter int TOL        = 2,
    parameter int LOCK_COUNT = 2
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] adc_data,
    input  logic        adc_valid,
    output logic        adc_ready,
    output note_t       note,
    output octave_t     octave,
    output logic [7:0]  volume,
    output logic        tone_valid
);

    localparam int             MW       = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0]  LOCK_MAX = MW'(LOCK_COUNT);

    tone_dec_state_t state;
    logic [11:0]     count;
    logic [11:0]     h;
    logic [16:0]     peak;
    logic [16:0]     p;
    logic            sign;
    note_t           scan_n, best_n, pending_n;
    octave_t         scan_o, best_o, pending_o;
    logic [12:0]     best_diff;
    logic [MW-1:0]   match_cnt;

    logic            accept;
    logic            sample_sign;
    logic            crossing;
    logic [16:0]     sample_abs;
    logic [11:0]     cand;
    logic [12:0]     cand_diff;
    logic            is_match;
    logic [MW-1:0]   match_next;

    tone_div_rom u_rom (
        .note        (scan_n),
        .octave      (scan_o),
        .half_period (cand)
    );

    // A zero sample carries no polarity, so it never counts as a crossing.
    always_comb begin
        accept      = adc_valid && adc_ready;
        sample_sign = (adc_data == 16'd0) ? sign : adc_data[15];
        crossing    = accept && (sample_sign != sign);
        sample_abs  = adc_data[15] ? (17'd0 - {adc_data[15], adc_data}) : {1'b0, adc_data};
        cand_diff   = (cand >= h) ? {1'b0, cand - h} : {1'b0, h - cand};
        is_match    = (best_diff <= 13'(TOL));
        match_next  = MW'(1);
        if ((best_n == pending_n) && (best_o == pending_o)) begin
            match_next = (match_cnt == LOCK_MAX) ? LOCK_MAX : match_cnt + MW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            adc_ready  <= 1'b1;
            count      <= '0;
            h          <= '0;
            peak       <= '0;
            p          <= '0;
            sign       <= 1'b0;
            scan_n     <= '0;
            scan_o     <= '0;
            best_n     <= '0;
            best_o     <= '0;
            best_diff  <= '1;
            pending_n  <= '0;
            pending_o  <= '0;
            match_cnt  <= '0;
            note       <= '0;
            octave     <= '0;
            volume     <= '0;
            tone_valid <= 1'b0;
        end else begin
            if (accept) begin
                sign <= sample_sign;
            end
            case (state)
                IDLE: begin
                    if (crossing) begin
                        count <= 12'd1;
                        peak  <= sample_abs;
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (crossing) begin
                        h         <= count;
                        p         <= peak;
                        count     <= 12'd1;
                        peak      <= sample_abs;
                        scan_n    <= '0;
                        scan_o    <= '0;
                        best_diff <= '1;
                        adc_ready <= 1'b0;
                        state     <= SEARCH;
                    end else if (accept) begin
                        if (sample_abs > peak) begin
                            peak <= sample_abs;
                        end
                        if (count != 12'hFFF) begin
                            count <= count + 12'd1;
                        end
                        // A half-period this long is silence or DC: drop the lock.
                        if (count >= 12'hFFE) begin
                            tone_valid <= 1'b0;
                            match_cnt  <= '0;
                            state      <= IDLE;
                        end
                    end
                end
                SEARCH: begin
                    if (cand_diff < best_diff) begin
                        best_diff <= cand_diff;
                        best_n    <= scan_n;
                        best_o    <= scan_o;
                    end
                    if (scan_o == 3'd7) begin
                        scan_o <= '0;
                        if (scan_n == 4'd11) begin
                            state <= DECIDE;
                        end else begin
                            scan_n <= scan_n + 4'd1;
                        end
                    end else begin
                        scan_o <= scan_o + 3'd1;
                    end
                end
                DECIDE: begin
                    if (is_match) begin
                        pending_n <= best_n;
                        pending_o <= best_o;
                        match_cnt <= match_next;
                        if (match_next == LOCK_MAX) begin
                            note       <= best_n;
                            octave     <= best_o;
                            volume     <= (p > 17'd255) ? 8'hFF : p[7:0];
                            tone_valid <= 1'b1;
                        end
                    end else begin
                        match_cnt  <= '0;
                        tone_valid <= 1'b0;
                    end
                    adc_ready <= 1'b1;
                    state     <= MEASURE;
                end
                default: begin
                    adc_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
